// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//
// Single-clock 514 x 32 FIFO controller around one SRAM1R1W512x32 macro.
// Enqueued words are written into the macro (512 entries). Each read issued
// to the macro returns its word one cycle later, and that word is pushed into
// a 2-entry skid buffer. The skid head drives the dequeue interface. The skid
// absorbs the macro's registered read latency, so one enqueue and one dequeue
// can both complete in every cycle.
//
// Optional build macro:
//   SRAM_FIFO_BYPASS_EN - when the macro holds nothing, no read is in flight
//                         and the skid has room, an enqueued word goes
//                         straight into the skid tail. No SRAM write occurs,
//                         and the word can be dequeued one edge after it is
//                         enqueued.
//
// Ports:
//   clk        design clock (the parent also ties it to SRAM CE1/CE2)
//   reset      asynchronous, active-high
//   enq_val    producer has data          enq_rdy   controller accepts data
//   enq_bits   enqueue data (32)
//   deq_val    head entry valid           deq_rdy   consumer takes head
//   deq_bits   head entry data (32), 0 when empty
//   count      entries held: SRAM + in-flight read + skid (0..514)
//   sram_a1    read address               sram_csb1 read select (active-low)
//   sram_oeb1  read output enable, tied 0 sram_o1   read data from the macro
//   sram_a2    write address              sram_csb2 write select (active-low)
//   sram_web2  write enable (active-low)  sram_i2   write data (= enq_bits)
// -----------------------------------------------------------------------------
module sram_fifo_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        enq_val,
   output logic        enq_rdy,
   input  logic [31:0] enq_bits,
   output logic        deq_val,
   input  logic        deq_rdy,
   output logic [31:0] deq_bits,
   output logic [9:0]  count,
   output logic [8:0]  sram_a1,
   output logic        sram_csb1,
   output logic        sram_oeb1,
   input  logic [31:0] sram_o1,
   output logic [8:0]  sram_a2,
   output logic        sram_csb2,
   output logic        sram_web2,
   output logic [31:0] sram_i2
);

   localparam logic [9:0] RAM_DEPTH = 10'd512;

   // Registered state
   logic [8:0]  wr_ptr_reg;
   logic [8:0]  rd_ptr_reg;
   logic [9:0]  ram_cnt_reg;
   logic        inflight_reg;
   logic [1:0]  skid_cnt_reg;
   logic [31:0] skid_data_reg [2];   // slot 0 is always the head

   // Next-state and handshake terms
   logic [8:0]  wr_ptr_next;
   logic [8:0]  rd_ptr_next;
   logic [9:0]  ram_cnt_next;
   logic        inflight_next;
   logic [1:0]  skid_cnt_next;
   logic [31:0] skid_data_next [2];

   logic        enq_fire;
   logic        deq_fire;
   logic        rd_go;
   logic        ram_wr;
   logic        bypass_go;
   logic        skid_push;
   logic        push_idx;
   logic [31:0] push_data;
   logic [2:0]  occ_after;

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   // Full is judged on the SRAM alone. A read issued in the same cycle
   // does not free a slot early, so there is no enqueue-to-read
   // pass-through at full.
   assign enq_rdy  = (ram_cnt_reg != RAM_DEPTH) & ~reset;
   assign enq_fire = enq_val & enq_rdy;

   assign deq_val  = (skid_cnt_reg != 2'd0);
   assign deq_fire = deq_val & deq_rdy;
   assign deq_bits = deq_val ? skid_data_reg[0] : 32'd0;

   // A read is issued only if its word is certain to find a skid slot one
   // edge later. The occupancy counts words already in the skid, plus a
   // word returning this cycle, minus a word leaving this cycle.
   // deq_fire implies skid_cnt_reg >= 1, so the subtraction cannot wrap.
   assign occ_after = {1'b0, skid_cnt_reg} + {2'b00, inflight_reg}
                    - {2'b00, deq_fire};
   assign rd_go     = (ram_cnt_reg != 10'd0) & (occ_after < 3'd2);

`ifdef SRAM_FIFO_BYPASS_EN
   logic [2:0] skid_after;

   // Bypass only when nothing older sits in the SRAM or is in flight.
   // Everything older is then already in the skid, so FIFO order holds.
   assign skid_after = {1'b0, skid_cnt_reg} - {2'b00, deq_fire};
   assign bypass_go  = enq_fire & (ram_cnt_reg == 10'd0) & ~inflight_reg
                     & (skid_after < 3'd2);
`else
   assign bypass_go  = 1'b0;
`endif

   assign ram_wr = enq_fire & ~bypass_go;

   // ------------------------------------------------------------------
   // SRAM ports
   // ------------------------------------------------------------------
   assign sram_a1   = rd_ptr_reg;
   assign sram_csb1 = ~rd_go;
   assign sram_oeb1 = 1'b0;
   assign sram_a2   = wr_ptr_reg;
   assign sram_csb2 = ~ram_wr;
   assign sram_web2 = ~ram_wr;
   assign sram_i2   = enq_bits;

   // ------------------------------------------------------------------
   // Skid buffer
   // ------------------------------------------------------------------
   // A returning SRAM word and a bypassed word are mutually exclusive:
   // bypass requires inflight_reg == 0.
   assign skid_push = inflight_reg | bypass_go;
   assign push_data = inflight_reg ? sram_o1 : enq_bits;

   // The tail slot after any pop is (skid_cnt - deq_fire). A push never
   // happens with two entries and no pop, so the low bit of that
   // difference is enough: cnt[0] ^ pop covers (0,0)->0, (1,0)->1,
   // (1,1)->0 and (2,1)->1.
   assign push_idx = skid_cnt_reg[0] ^ deq_fire;

   always_comb begin
      skid_data_next[0] = skid_data_reg[0];
      skid_data_next[1] = skid_data_reg[1];
      // A pop shifts slot 1 into the head. A push in the same cycle then
      // lands in the slot that the pop left free.
      if (deq_fire) begin
         skid_data_next[0] = skid_data_reg[1];
      end
      if (skid_push) begin
         skid_data_next[push_idx] = push_data;
      end
   end

   assign skid_cnt_next = skid_cnt_reg + {1'b0, skid_push} - {1'b0, deq_fire};

   // ------------------------------------------------------------------
   // Pointers and counters
   // ------------------------------------------------------------------
   // The 9-bit pointers wrap 511 -> 0 naturally.
   assign wr_ptr_next   = ram_wr ? (wr_ptr_reg + 9'd1) : wr_ptr_reg;
   assign rd_ptr_next   = rd_go  ? (rd_ptr_reg + 9'd1) : rd_ptr_reg;
   assign ram_cnt_next  = ram_cnt_reg + {9'd0, ram_wr} - {9'd0, rd_go};
   assign inflight_next = rd_go;

   assign count = ram_cnt_reg + {9'd0, inflight_reg} + {8'd0, skid_cnt_reg};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg       <= 9'd0;
         rd_ptr_reg       <= 9'd0;
         ram_cnt_reg      <= 10'd0;
         inflight_reg     <= 1'b0;
         skid_cnt_reg     <= 2'd0;
         skid_data_reg[0] <= 32'd0;
         skid_data_reg[1] <= 32'd0;
      end else begin
         wr_ptr_reg       <= wr_ptr_next;
         rd_ptr_reg       <= rd_ptr_next;
         ram_cnt_reg      <= ram_cnt_next;
         inflight_reg     <= inflight_next;
         skid_cnt_reg     <= skid_cnt_next;
         skid_data_reg[0] <= skid_data_next[0];
         skid_data_reg[1] <= skid_data_next[1];
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
//
// Testbench for sram_fifo_ctrl with a behavioural 1R1W 512x32 SRAM that
// has a registered read. Stimulus drives the inputs 1 time unit after the
// rising edge. An accepted enqueue pushes its word into the expected queue.
// A monitor running on the falling edge checks count against the queue
// depth, and checks each dequeued word against the queue head.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;

`ifdef SRAM_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        enq_val;
   logic        enq_rdy;
   logic [31:0] enq_bits;
   logic        deq_val;
   logic        deq_rdy;
   logic [31:0] deq_bits;
   logic [9:0]  count;
   logic [8:0]  sram_a1;
   logic        sram_csb1;
   logic        sram_oeb1;
   logic [31:0] sram_o1 = 32'd0;
   logic [8:0]  sram_a2;
   logic        sram_csb2;
   logic        sram_web2;
   logic [31:0] sram_i2;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_deq    = 0;
   logic [31:0] exp_q [$];
   logic [31:0] sram_mem [512];

   always #5 clk = ~clk;

   sram_fifo_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .enq_val   (enq_val),
      .enq_rdy   (enq_rdy),
      .enq_bits  (enq_bits),
      .deq_val   (deq_val),
      .deq_rdy   (deq_rdy),
      .deq_bits  (deq_bits),
      .count     (count),
      .sram_a1   (sram_a1),
      .sram_csb1 (sram_csb1),
      .sram_oeb1 (sram_oeb1),
      .sram_o1   (sram_o1),
      .sram_a2   (sram_a2),
      .sram_csb2 (sram_csb2),
      .sram_web2 (sram_web2),
      .sram_i2   (sram_i2)
   );

   // Behavioural macro: registered read. The output holds until the next read.
   always @(posedge clk) begin
      if (!sram_csb2 && !sram_web2) sram_mem[sram_a2] <= sram_i2;
      if (!sram_csb1) sram_o1 <= sram_mem[sram_a1];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: the falling edge is mid-cycle. Register state is stable and
   // the inputs for the upcoming edge are already applied.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         check("count_vs_depth", 32'(count), 32'(exp_q.size()));
         if (deq_val && deq_rdy) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL deq_unexpected: got %h expected no word", deq_bits);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               $display("DEQ %08h exp %08h depth %0d", deq_bits, e, exp_q.size());
               check("deq_order", deq_bits, e);
               n_deq++;
            end
         end
      end
   end

   // One clock cycle of stimulus. On return the time is just after the
   // falling edge, so the inputs are still applied and the edge has not
   // yet fired.
   task automatic cycle(input logic v, input logic [31:0] d, input logic rdy, output bit fired);
      @(posedge clk);
      #1;
      enq_val  = v;
      enq_bits = d;
      deq_rdy  = rdy;
      @(negedge clk);
      #1;
      fired = enq_val && enq_rdy;
      if (fired) exp_q.push_back(enq_bits);
   endtask

   task automatic wait_empty(input int budget);
      bit f;
      int i;
      for (i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && count == 10'd0) break;
         cycle(1'b0, 32'd0, 1'b1, f);
      end
      check("drain_within_budget", 32'(i < budget), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit f;
      int pushed;
      int gaps;
      int fires;

      reset    = 1'b1;
      enq_val  = 1'b0;
      enq_bits = 32'd0;
      deq_rdy  = 1'b0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #2;
      check("rst_enq_rdy",  32'(enq_rdy),   32'd0);
      check("rst_deq_val",  32'(deq_val),   32'd0);
      check("rst_deq_bits", deq_bits,       32'd0);
      check("rst_count",    32'(count),     32'd0);
      check("rst_csb1",     32'(sram_csb1), 32'd1);
      check("rst_csb2",     32'(sram_csb2), 32'd1);
      check("rst_web2",     32'(sram_web2), 32'd1);
      check("rst_oeb1",     32'(sram_oeb1), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_enq_rdy", 32'(enq_rdy), 32'd1);

      // ---------------- single enqueue, latency ----------------
      cycle(1'b1, 32'hA5A5_0001, 1'b0, f);
      check("single_fired", 32'(f),         32'd1);
      check("single_csb2",  32'(sram_csb2), 32'(BYP));
      check("single_web2",  32'(sram_web2), 32'(BYP));
      check("single_a2",    32'(sram_a2),   32'd0);
      cycle(1'b0, 32'd0, 1'b0, f);
      check("lat_edge1_deq_val", 32'(deq_val), 32'(BYP));
      cycle(1'b0, 32'd0, 1'b0, f);
      check("lat_edge2_pre_deq_val", 32'(deq_val), 32'(BYP));
      cycle(1'b0, 32'd0, 1'b0, f);
      check("lat_edge3_deq_val", 32'(deq_val), 32'd1);
      check("single_deq_bits",   deq_bits,     32'hA5A5_0001);
      check("single_count",      32'(count),   32'd1);
      wait_empty(20);

      // ---------------- fill to 514, then drain ----------------
      pushed = 0;
      for (int i = 0; i < 1000 && pushed < 514; i++) begin
         cycle(1'b1, 32'(pushed), 1'b0, f);
         if (f) pushed++;
      end
      check("fill_pushed", 32'(pushed), 32'd514);
      cycle(1'b1, 32'hDEAD_BEEF, 1'b0, f);
      check("full_enq_rdy", 32'(enq_rdy), 32'd0);
      check("full_count",   32'(count),   32'd514);
      check("full_no_fire", 32'(f),       32'd0);
      wait_empty(700);

      // ---------------- continuous enq + deq ----------------
      gaps  = 0;
      fires = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b1, f);
         if (f) fires++;
         if (i >= 4 && !deq_val) gaps++;
      end
      check("stream_fires", 32'(fires), 32'd1000);
      check("stream_gaps",  32'(gaps),  32'd0);
      wait_empty(20);

      // ---------------- random traffic ----------------
      for (int i = 0; i < 20000; i++) begin
         logic ev;
         logic dr;
         if (i < 10000) begin
            ev = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 3) == 0);
         end else begin
            ev = ($urandom_range(0, 3) == 0);
            dr = ($urandom_range(0, 3) != 0);
         end
         cycle(ev, $urandom, dr, f);
      end
      wait_empty(1200);

      // ---------------- async reset mid-operation ----------------
      pushed = 0;
      for (int i = 0; i < 600 && pushed < 300; i++) begin
         cycle(1'b1, 32'hC000_0000 + 32'(pushed), 1'b0, f);
         if (f) pushed++;
      end
      // Simultaneous enq + deq keeps count at 300 and starts a read.
      cycle(1'b1, 32'hC000_FFFF, 1'b1, f);
      check("pre_rst_count", 32'(count), 32'd300);
      @(posedge clk);
      #3;
      reset   = 1'b1;
      enq_val = 1'b0;
      deq_rdy = 1'b0;
      exp_q.delete();
      #1;
      check("arst_count",    32'(count),     32'd0);
      check("arst_deq_val",  32'(deq_val),   32'd0);
      check("arst_deq_bits", deq_bits,       32'd0);
      check("arst_enq_rdy",  32'(enq_rdy),   32'd0);
      check("arst_csb1",     32'(sram_csb1), 32'd1);
      check("arst_csb2",     32'(sram_csb2), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      n_deq = 0;
      cycle(1'b1, 32'h1234_5678, 1'b0, f);
      check("post_arst_fired", 32'(f), 32'd1);
      wait_empty(20);
      check("post_arst_deq_cnt", 32'(n_deq), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
